alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, registered ALU that supersedes the 4-bit combinational ALU in the CPU controller datapath. It accepts one operation per valid/ready handshake and returns a registered result plus carry/zero/overflow/negative flags. It adds subtract, shifts and a multi-cycle shift-add multiply. The controller issues operands and drains results through independent input and output handshakes, with back-pressure.

Parameters:
WIDTH, 8, operand/result width; power of two, minimum 4
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid  input  1  operands/op valid
in_ready  output  1  block can accept an operation
a  input  WIDTH  operand A
b  input  WIDTH  operand B
sel  input  3  opcode
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts the result
out  output  WIDTH  result
carry_out  output  1  carry/borrow/shifted-out bit
zero_flag  output  1  out == 0
overflow_flag  output  1  signed overflow
neg_flag  output  1  out[WIDTH-1]

Behaviour:
- Opcodes: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SHL, 110 SHR (logical), 111 MUL.
- Reset (asynchronous, any cycle including mid-MUL):
  - State goes to IDLE.
  - out, carry_out, overflow_flag, neg_flag and out_valid clear to 0; zero_flag clears to 1 (out == 0).
  - in_ready is 0 while rst is high.
  - Internal accumulator and counter clear to 0.
- States:
  - IDLE: in_ready=1, out_valid=0.
    - in_valid=1 with sel!=111: compute the result, register it into out and the flags, go to DONE. Latency is 1 cycle from acceptance to out_valid.
    - in_valid=1 with sel==111: load multiplicand a into a 2*WIDTH shift register, load multiplier b, clear the 2*WIDTH accumulator, set count=WIDTH, go to MUL.
  - MUL: in_ready=0, out_valid=0.
    - Each cycle: if multiplier[0], acc += multiplicand; then shift multiplicand left 1 and multiplier right 1; count decrements.
    - When count reaches 0 (after WIDTH cycles), register the flags and out = acc[WIDTH-1:0], go to DONE.
    - Total latency is WIDTH+1 cycles from acceptance to out_valid.
  - DONE: out_valid=1, in_ready=0. out and the flags are held stable. When out_ready=1, go to IDLE (out_valid drops the next cycle). Throughput is at most one operation per 2 cycles; there is no same-cycle accept in DONE.
- Width/flag rules (all results truncated to WIDTH):
  - AND/OR/XOR: carry=0, overflow=0.
  - ADD: sum is WIDTH+1 bits; carry=sum[WIDTH]; overflow=(a.msb==b.msb)&&(out.msb!=a.msb).
  - SUB: out=a-b; carry=borrow=(a<b unsigned); overflow=(a.msb!=b.msb)&&(out.msb!=a.msb).
  - SHL/SHR: amount=b[SHW-1:0]; upper bits of b are ignored. carry=last bit shifted out (SHL: a[WIDTH-amount], SHR: a[amount-1]); carry=0 when amount=0; overflow=0.
  - MUL: unsigned; carry=|acc[2*WIDTH-1:WIDTH]; overflow=0.
  - All ops: zero_flag=(out==0); neg_flag=out[WIDTH-1].
- Inputs are sampled only on the in_valid&&in_ready cycle. Changes to a, b or sel afterwards do not affect an in-flight operation.
- in_valid while in_ready=0 is ignored, not queued. An undefined sel is not possible (full 3-bit decode).

Test Plan:
- WIDTH=8, ADD 0x7F+0x01 -> out=0x80, carry=0, overflow=1, neg=1, zero=0; out_valid exactly 1 cycle after accept.
- ADD 0xFF+0x01 -> out=0x00, carry=1, zero=1, overflow=0; SUB 0x03-0x05 -> out=0xFE, carry=1, neg=1, overflow=0; SUB 0x80-0x01 -> out=0x7F, overflow=1.
- SHL 0x81 by b=0x09 (amount=1) -> out=0x02, carry=1; SHR 0x81 by 0 -> out=0x81, carry=0; SHR 0x81 by 7 -> out=0x01, carry=0.
- MUL 0x0F*0x11 -> out=0xFF, carry=0, out_valid 9 cycles after accept; MUL 0x10*0x10 -> out=0x00, carry=1, zero=1; in_ready=0 throughout MUL.
- Back-pressure: hold out_ready=0 for 5 cycles after an XOR 0xAA^0x55 -> out=0xFF stays stable with out_valid=1, in_ready=0, and an in_valid pulse meanwhile is ignored. Raise out_ready -> IDLE next cycle.
- Assert rst asynchronously on the 4th MUL cycle -> outputs clear immediately, in_ready=0 during reset. After release: in_ready=1, and a new ADD 0x01+0x01 returns 0x02 with no residue from the aborted multiply.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq: valid/ready in, valid/ready out.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       sel;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             carry_out;
    logic             zero_flag;
    logic             overflow_flag;
    logic             neg_flag;

    modport master (
        output in_valid, a, b, sel, out_ready,
        input  in_ready, out_valid, out, carry_out, zero_flag, overflow_flag, neg_flag
    );

    modport slave (
        input  in_valid, a, b, sel, out_ready,
        output in_ready, out_valid, out, carry_out, zero_flag, overflow_flag, neg_flag
    );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with flags; single-cycle logic/arith/shift ops and a
// WIDTH-cycle shift-add multiply, behind independent in/out handshakes.
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    alu_seq_if.slave    bus
);
    localparam int unsigned SHW   = $clog2(WIDTH);
    localparam int unsigned CNT_W = SHW + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic               in_ready_i;
    logic               out_valid_i;
    logic               accept;
    logic               last_step;

    logic [WIDTH-1:0]   res;
    logic               carry;
    logic               ovf;
    logic               zero;
    logic               neg;

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_next;
    logic [CNT_W-1:0]   count;

    logic [WIDTH-1:0]   alu_res;
    logic               alu_c;
    logic               alu_v;
    logic [WIDTH:0]     sum_w;
    logic [WIDTH:0]     diff_w;
    logic [WIDTH:0]     shl_w;
    logic [WIDTH:0]     shr_w;
    logic [SHW-1:0]     amt;

    assign accept    = bus.in_valid && in_ready_i;
    assign last_step = (count == CNT_W'(1));
    assign acc_next  = acc + (mplier[0] ? mcand : '0);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = (bus.sel == 3'b111) ? S_MUL : S_DONE;
                end
            end
            S_MUL: begin
                if (last_step) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Handshake outputs; in_ready is forced low while reset is held
    always_comb begin
        in_ready_i  = 1'b0;
        out_valid_i = 1'b0;
        case (state)
            S_IDLE:  in_ready_i  = !rst;
            S_DONE:  out_valid_i = 1'b1;
            default: ;
        endcase
    end

    // Single-cycle datapath; shifts carry the last bit out via one extra bit
    always_comb begin
        amt     = bus.b[SHW-1:0];
        sum_w   = {1'b0, bus.a} + {1'b0, bus.b};
        diff_w  = {1'b0, bus.a} - {1'b0, bus.b};
        shl_w   = {1'b0, bus.a} << amt;
        shr_w   = {bus.a, 1'b0} >> amt;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.sel)
            3'b000: alu_res = bus.a & bus.b;
            3'b001: alu_res = bus.a | bus.b;
            3'b010: alu_res = bus.a ^ bus.b;
            3'b011: begin
                alu_res = sum_w[WIDTH-1:0];
                alu_c   = sum_w[WIDTH];
                alu_v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                          (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'b100: begin
                alu_res = diff_w[WIDTH-1:0];
                alu_c   = diff_w[WIDTH];
                alu_v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                          (diff_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            3'b101: begin
                alu_res = shl_w[WIDTH-1:0];
                alu_c   = shl_w[WIDTH];
            end
            3'b110: begin
                alu_res = shr_w[WIDTH:1];
                alu_c   = shr_w[0];
            end
            default: ;
        endcase
    end

    // Result registers and multiplier state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res    <= '0;
            carry  <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b1;
            neg    <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
        end else if (accept) begin
            if (bus.sel == 3'b111) begin
                mcand  <= {{WIDTH{1'b0}}, bus.a};
                mplier <= bus.b;
                acc    <= '0;
                count  <= CNT_W'(WIDTH);
            end else begin
                res   <= alu_res;
                carry <= alu_c;
                ovf   <= alu_v;
                zero  <= (alu_res == '0);
                neg   <= alu_res[WIDTH-1];
            end
        end else if (state == S_MUL) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CNT_W'(1);
            if (last_step) begin
                res   <= acc_next[WIDTH-1:0];
                carry <= |acc_next[2*WIDTH-1:WIDTH];
                ovf   <= 1'b0;
                zero  <= (acc_next[WIDTH-1:0] == '0);
                neg   <= acc_next[WIDTH-1];
            end
        end
    end

    assign bus.in_ready      = in_ready_i;
    assign bus.out_valid     = out_valid_i;
    assign bus.out           = res;
    assign bus.carry_out     = carry;
    assign bus.zero_flag     = zero;
    assign bus.overflow_flag = ovf;
    assign bus.neg_flag      = neg;
endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed corner cases, back-pressure,
// mid-multiply reset and randomized ops against an arithmetic reference model.
module tb_alu_seq;
    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] o;
        logic         c;
        logic         z;
        logic         v;
        logic         n;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    int   failed = 0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operation's definition
    function automatic exp_t model(input int unsigned x, input int unsigned y, input int unsigned op);
        exp_t        e;
        int unsigned r;
        int unsigned amt;
        int          sx;
        int          sy;
        int          sr;
        amt = y % W;
        sx  = (x >= 128) ? int'(x) - 256 : int'(x);
        sy  = (y >= 128) ? int'(y) - 256 : int'(y);
        r   = 0;
        e   = '0;
        case (op)
            0: r = x & y;
            1: r = x | y;
            2: r = x ^ y;
            3: begin
                r   = x + y;
                e.c = (r > 255);
                sr  = sx + sy;
                e.v = (sr > 127) || (sr < -128);
            end
            4: begin
                r   = x + 256 - y;
                e.c = (x < y);
                sr  = sx - sy;
                e.v = (sr > 127) || (sr < -128);
            end
            5: begin
                r   = x << amt;
                e.c = (amt != 0) && (((x >> (W - amt)) & 1) != 0);
            end
            6: begin
                r   = x >> amt;
                e.c = (amt != 0) && (((x >> (amt - 1)) & 1) != 0);
            end
            default: begin
                r   = x * y;
                e.c = (r > 255);
            end
        endcase
        e.o = 8'(r % 256);
        e.z = (e.o == 8'h00);
        e.n = e.o[W-1];
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t e);
        check({tag, ".out"},  32'(bus.out),           32'(e.o));
        check({tag, ".c"},    32'(bus.carry_out),     32'(e.c));
        check({tag, ".z"},    32'(bus.zero_flag),     32'(e.z));
        check({tag, ".v"},    32'(bus.overflow_flag), 32'(e.v));
        check({tag, ".n"},    32'(bus.neg_flag),      32'(e.n));
    endtask

    // Issue one op and wait for out_valid; operands are scrambled after accept
    task automatic issue(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] ts,
                         input string tag);
        int   lat;
        logic busy_ready;
        @(negedge clk);
        check({tag, ".idle_ready"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = ta;
        bus.b        = tb_v;
        bus.sel      = ts;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.a        = 8'($urandom);
        bus.b        = 8'($urandom);
        bus.sel      = 3'($urandom);
        lat        = 1;
        busy_ready = 1'b0;
        while (!bus.out_valid && lat < 40) begin
            if (bus.in_ready) busy_ready = 1'b1;
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, ".latency"}, 32'(lat), (ts == 3'b111) ? 32'(W + 1) : 32'd1);
        check({tag, ".busy_ready"}, 32'(busy_ready), 32'd0);
    endtask

    task automatic drain(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check({tag, ".drain_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".drain_ready"}, 32'(bus.in_ready), 32'd1);
    endtask

    task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [2:0] ts,
                          input string tag);
        issue(ta, tb_v, ts, tag);
        check_result(tag, model(ta, tb_v, ts));
        drain(tag);
    endtask

    initial begin
        exp_t e;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [2:0] rs;
        int unsigned hold;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sel       = '0;

        // Reset values
        #12;
        check("rst.in_ready",  32'(bus.in_ready),  32'd0);
        check("rst.out_valid", 32'(bus.out_valid), 32'd0);
        check_result("rst", '{o: 8'h00, c: 1'b0, z: 1'b1, v: 1'b0, n: 1'b0});
        @(negedge clk);
        rst = 1'b0;

        // Directed corner cases
        run_op(8'h7F, 8'h01, 3'b011, "add_ovf");
        check("add_ovf.const_out", 32'(bus.out), 32'h80);
        run_op(8'hFF, 8'h01, 3'b011, "add_carry");
        run_op(8'h03, 8'h05, 3'b100, "sub_borrow");
        run_op(8'h80, 8'h01, 3'b100, "sub_ovf");
        run_op(8'h81, 8'h09, 3'b101, "shl1");
        check("shl1.const_out", 32'(bus.out), 32'h02);
        run_op(8'h81, 8'h00, 3'b110, "shr0");
        run_op(8'h81, 8'h07, 3'b110, "shr7");
        run_op(8'h0F, 8'h11, 3'b111, "mul_ff");
        check("mul_ff.const_out", 32'(bus.out), 32'hFF);
        run_op(8'h10, 8'h10, 3'b111, "mul_wrap");
        run_op(8'hC3, 8'h3C, 3'b000, "and");
        run_op(8'hC3, 8'h3C, 3'b001, "or");

        // Back-pressure: result held, stray in_valid ignored
        issue(8'hAA, 8'h55, 3'b010, "bp");
        for (int unsigned i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.in_valid = (i == 2);
            bus.a        = 8'h01;
            bus.b        = 8'h01;
            bus.sel      = 3'b011;
            check("bp.out",       32'(bus.out),       32'hFF);
            check("bp.out_valid", 32'(bus.out_valid), 32'd1);
            check("bp.in_ready",  32'(bus.in_ready),  32'd0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        drain("bp");
        check("bp.after_out", 32'(bus.out), 32'hFF);

        // Asynchronous reset during the 4th multiply cycle
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 8'hC3;
        bus.b        = 8'h5A;
        bus.sel      = 3'b111;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst.in_ready",  32'(bus.in_ready),  32'd0);
        check("arst.out_valid", 32'(bus.out_valid), 32'd0);
        check_result("arst", '{o: 8'h00, c: 1'b0, z: 1'b1, v: 1'b0, n: 1'b0});
        @(posedge clk);
        #1;
        check("arst.hold_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("arst.release_ready", 32'(bus.in_ready), 32'd1);
        run_op(8'h01, 8'h01, 3'b011, "post_rst_add");
        check("post_rst_add.const_out", 32'(bus.out), 32'h02);

        // Randomized ops with random back-pressure
        for (int unsigned n = 0; n < 40; n++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rs   = 3'($urandom_range(7, 0));
            hold = $urandom_range(3, 0);
            issue(ra, rb, rs, "rnd");
            e = model(ra, rb, rs);
            for (int unsigned k = 0; k < hold; k++) begin
                @(negedge clk);
                check("rnd.hold_valid", 32'(bus.out_valid), 32'd1);
            end
            check_result("rnd", e);
            drain("rnd");
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
